// File: rtl/iccm_port_arb.sv
// rtl/iccm_port_arb.sv - single-port ICCM SRAM arbiter between programmer writes and fetch reads
// Writes wait for all in-flight reads to drain; streak limits bound starvation both ways.
module iccm_port_arb #(
  parameter int Aw        = 12,
  parameter int Dw        = 32,
  parameter int MaxOutst  = 2,
  parameter int MaxStreak = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          prog_req_i,
  input  logic [Aw-1:0] prog_addr_i,
  input  logic [Dw-1:0] prog_wdata_i,
  output logic          prog_gnt_o,
  input  logic          fetch_req_i,
  input  logic [Aw-1:0] fetch_addr_i,
  output logic          fetch_gnt_o,
  output logic          fetch_rvalid_o,
  output logic [Dw-1:0] fetch_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [Aw-1:0] mem_addr_o,
  output logic [Dw-1:0] mem_wdata_o,
  input  logic [Dw-1:0] mem_rdata_i,
  input  logic          mem_rvalid_i,
  output logic          proto_err_o
);

  localparam int OW = $clog2(MaxOutst + 1);
  localparam int SW = $clog2(MaxStreak + 1);
  localparam logic [OW-1:0] OutstMax  = OW'(MaxOutst);
  localparam logic [SW-1:0] StreakMax = SW'(MaxStreak);

  typedef enum logic [1:0] {
    ST_RD   = 2'd0,
    ST_TURN = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          proto_err_q, proto_err_d;
  logic          prog_gnt, fetch_gnt, switch_rd, back_wr, other_req, rd_ret;

  always_comb begin
    prog_gnt  = 1'b0;
    fetch_gnt = 1'b0;
    switch_rd = 1'b0;
    back_wr   = 1'b0;
    other_req = 1'b0;
    case (state_q)
      ST_RD: begin
        other_req = prog_req_i;
        switch_rd = prog_req_i && (!fetch_req_i || streak_q == StreakMax);
        fetch_gnt = !switch_rd && fetch_req_i && (outst_q < OutstMax);
      end
      ST_WR: begin
        other_req = fetch_req_i;
        back_wr   = !prog_req_i || (fetch_req_i && streak_q == StreakMax);
        prog_gnt  = !back_wr && prog_req_i;
      end
      default: ;
    endcase
    // Grants are forced low while reset is held, even though state is already RD.
    if (!rst_ni) begin
      prog_gnt  = 1'b0;
      fetch_gnt = 1'b0;
    end
  end

  always_comb begin
    rd_ret      = mem_rvalid_i && (outst_q != '0);
    outst_d     = outst_q + OW'(fetch_gnt) - OW'(rd_ret);
    proto_err_d = proto_err_q || (mem_rvalid_i && (outst_q == '0));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RD:   if (switch_rd) state_d = (outst_d == '0) ? ST_WR : ST_TURN;
      ST_TURN: if (outst_q == '0) state_d = ST_WR;
      ST_WR:   if (back_wr) state_d = ST_RD;
      default: state_d = ST_RD;
    endcase
    streak_d = streak_q;
    if (state_d != state_q || !other_req) begin
      streak_d = '0;
    end else if ((prog_gnt || fetch_gnt) && streak_q != StreakMax) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RD;
      outst_q     <= '0;
      streak_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      outst_q     <= outst_d;
      streak_q    <= streak_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign prog_gnt_o     = prog_gnt;
  assign fetch_gnt_o    = fetch_gnt;
  assign mem_req_o      = prog_gnt || fetch_gnt;
  assign mem_we_o       = prog_gnt;
  assign mem_addr_o     = prog_gnt ? prog_addr_i : (rst_ni ? fetch_addr_i : '0);
  assign mem_wdata_o    = prog_gnt ? prog_wdata_i : '0;
  assign fetch_rvalid_o = mem_rvalid_i;
  assign fetch_rdata_o  = mem_rdata_i;
  assign proto_err_o    = proto_err_q;

endmodule

// File: tb/tb_iccm_port_arb.sv
// tb/tb_iccm_port_arb.sv - self-checking bench for iccm_port_arb against a queue-based port-ownership model
module tb_iccm_port_arb;
  localparam int MAXO = 2;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_req, fetch_req, mem_rvalid;
  logic [11:0] prog_addr, fetch_addr;
  logic [31:0] prog_wdata, mem_rdata;
  logic        prog_gnt_o, fetch_gnt_o, fetch_rvalid_o, mem_req_o, mem_we_o, proto_err_o;
  logic [31:0] fetch_rdata_o, mem_wdata_o;
  logic [11:0] mem_addr_o;

  always #5 clk = ~clk;

  iccm_port_arb #(.Aw(12), .Dw(32), .MaxOutst(MAXO), .MaxStreak(MAXS)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .prog_req_i(prog_req), .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata), .prog_gnt_o(prog_gnt_o),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt_o),
    .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid), .proto_err_o(proto_err_o)
  );

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  // Model: which side owns the port, whether the writer is waiting for reads to drain,
  // the list of reads in flight, and the length of the current grant run.
  int m_owner;
  bit m_drain;
  int m_q[$];
  int m_run;
  bit m_err;
  bit last_rd;
  bit e_pg, e_fg, m_yield;

  task automatic model_clear();
    m_owner = 0; m_drain = 0; m_q.delete(); m_run = 0; m_err = 0; last_rd = 0;
  endtask

  task automatic model_comb();
    if (!rst_n) model_clear();
    e_pg = 0; e_fg = 0; m_yield = 0;
    if (rst_n && !m_drain) begin
      if (m_owner == 0) begin
        m_yield = prog_req && (!fetch_req || m_run == MAXS);
        if (!m_yield) e_fg = fetch_req && (m_q.size() < MAXO);
      end else begin
        m_yield = !prog_req || (fetch_req && m_run == MAXS);
        if (!m_yield) e_pg = 1;
      end
    end
  endtask

  task automatic model_seq();
    int n0;
    bit other;
    if (!rst_n) begin model_clear(); return; end
    n0 = m_q.size();
    if (mem_rvalid) begin
      if (n0 == 0) m_err = 1;
      else void'(m_q.pop_front());
    end
    if (e_fg) m_q.push_back(int'(fetch_addr));
    if (m_drain) begin
      if (n0 == 0) begin m_drain = 0; m_owner = 1; end
      m_run = 0;
    end else if (m_yield) begin
      if (m_owner == 0) begin
        if (m_q.size() == 0) m_owner = 1; else m_drain = 1;
      end else m_owner = 0;
      m_run = 0;
    end else begin
      other = (m_owner == 0) ? prog_req : fetch_req;
      if (!other) m_run = 0;
      else if (e_pg || e_fg) m_run = (m_run < MAXS) ? m_run + 1 : MAXS;
    end
    last_rd = e_fg;
  endtask

  function automatic logic [81:0] exp_vec();
    logic [11:0] a;
    a = !rst_n ? 12'h0 : (e_pg ? prog_addr : fetch_addr);
    return {e_pg, e_fg, e_pg | e_fg, e_pg, a, e_pg ? prog_wdata : 32'h0, mem_rvalid, mem_rdata, m_err};
  endfunction

  function automatic logic [81:0] dut_vec();
    return {prog_gnt_o, fetch_gnt_o, mem_req_o, mem_we_o, mem_addr_o,
            (e_pg | e_fg) ? mem_wdata_o : 32'h0, fetch_rvalid_o, fetch_rdata_o, proto_err_o};
  endfunction

  task automatic drive(input logic p, input logic [11:0] pa, input logic [31:0] pd,
                       input logic f, input logic [11:0] fa, input logic rv);
    prog_req = p; prog_addr = pa; prog_wdata = pd;
    fetch_req = f; fetch_addr = fa; mem_rvalid = rv;
    mem_rdata = rv ? $urandom : 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_seq();
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 12'h0AA, 32'h1234_5678, 1'b1, 12'h055, 1'b0);
      @(negedge clk); model_comb();
      nvec++;
      if (dut_vec() !== exp_vec()) begin
        $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); nmis++;
      end
      tick();
    end
    rst_n = 1'b1;
    drive(1'b0, 12'h0, 32'h0, 1'b0, 12'h3C3, 1'b0);
    @(negedge clk); model_comb();
    nvec++;
    if (mem_req_o !== 1'b0 || mem_addr_o !== 12'h3C3 || proto_err_o !== 1'b0) begin
      $display("FAIL reset_idle got req=%b addr=%h err=%b exp req=0 addr=3c3 err=0",
               mem_req_o, mem_addr_o, proto_err_o); nmis++;
    end
    tick();
  endtask

  task automatic test_fetch_stream();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 12'h0, 32'h0, 1'b1, 12'h010, last_rd);
      @(negedge clk); model_comb();
      nvec++;
      if (dut_vec() !== exp_vec()) begin
        $display("FAIL fetch_stream cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); nmis++;
      end
      nvec++;
      if (fetch_gnt_o !== 1'b1 || proto_err_o !== 1'b0) begin
        $display("FAIL fetch_stream_gnt cyc=%0d got gnt=%b err=%b exp gnt=1 err=0", cyc, fetch_gnt_o, proto_err_o);
        nmis++;
      end
      tick();
    end
    drive(1'b0, 12'h0, 32'h0, 1'b0, 12'h010, last_rd);
    @(negedge clk); model_comb();
    tick();
  endtask

  task automatic test_outst_limit();
    int ngnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 12'h0, 32'h0, i < 8, 12'h020 + 12'(i), i == 6 || i >= 8);
      @(negedge clk); model_comb();
      if (i < 6 && fetch_gnt_o === 1'b1) ngnt++;
      nvec++;
      if (dut_vec() !== exp_vec()) begin
        $display("FAIL outst_limit cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); nmis++;
      end
      if (i == 6) begin
        nvec++;
        if (fetch_gnt_o !== 1'b0) begin
          $display("FAIL outst_stall_on_rvalid got=%b exp=0", fetch_gnt_o); nmis++;
        end
      end
      tick();
    end
    nvec++;
    if (ngnt != MAXO) begin
      $display("FAIL outst_grant_count got=%0d exp=%0d", ngnt, MAXO); nmis++;
    end
  endtask

  task automatic test_write_switch();
    for (int i = 0; i < 8; i++) begin
      drive(i < 6, 12'h123, 32'hDEAD_BEEF, 1'b0, 12'h040, 1'b0);
      @(negedge clk); model_comb();
      nvec++;
      if (dut_vec() !== exp_vec()) begin
        $display("FAIL write_switch cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); nmis++;
      end
      if (i >= 1 && i < 6) begin
        nvec++;
        if ({prog_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 12'h123, 32'hDEAD_BEEF}) begin
          $display("FAIL write_stream cyc=%0d got gnt=%b we=%b addr=%h data=%h exp 1 1 123 deadbeef",
                   cyc, prog_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o); nmis++;
        end
      end else if (i == 0) begin
        nvec++;
        if (prog_gnt_o !== 1'b0) begin
          $display("FAIL write_turn_cycle got=%b exp=0", prog_gnt_o); nmis++;
        end
      end
      tick();
    end
  endtask

  task automatic test_both_high();
    int wp = 0, wf = 0, max_wp = 0, max_wf = 0, n_pg = 0, n_fg = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 12'($urandom), $urandom, 1'b1, 12'($urandom), last_rd);
      @(negedge clk); model_comb();
      nvec++;
      if (dut_vec() !== exp_vec()) begin
        $display("FAIL both_high cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); nmis++;
      end
      if (prog_gnt_o === 1'b1) begin wp = 0; n_pg++; end else wp++;
      if (fetch_gnt_o === 1'b1) begin wf = 0; n_fg++; end else wf++;
      if (wp > max_wp) max_wp = wp;
      if (wf > max_wf) max_wf = wf;
      tick();
    end
    nvec++;
    if (max_wp > MAXS + 2 || max_wf > MAXS + 2) begin
      $display("FAIL starvation_bound got wait_w=%0d wait_r=%0d exp <=%0d", max_wp, max_wf, MAXS + 2); nmis++;
    end
    nvec++;
    if (n_pg < 12 || n_fg < 12) begin
      $display("FAIL both_share got writes=%0d reads=%0d exp >=12 each", n_pg, n_fg); nmis++;
    end
  endtask

  task automatic test_turn();
    int we_bad = 0;
    bit p;
    for (int i = 0; i < 34; i++) begin
      // Two phases: prog held through drain, then prog pulsed for one cycle and dropped in TURN.
      case (i)
        0, 1, 2:  drive(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, last_rd);
        3, 4:     drive(1'b0, 12'h0, 32'h0, 1'b1, 12'h080, 1'b0);
        5, 6, 7, 8, 11, 12, 13, 14:
                  drive(1'b1, 12'h200 + 12'(i), $urandom, 1'b0, 12'h0, 1'b0);
        9, 10:    drive(1'b1, 12'h0, 32'h0, 1'b0, 12'h0, 1'b1);
        15, 16, 17: drive(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 1'b0);
        18, 19:   drive(1'b0, 12'h0, 32'h0, 1'b1, 12'h090, 1'b0);
        20:       drive(1'b1, 12'h300, 32'hCAFE_0000, 1'b0, 12'h0, 1'b0);
        23, 25:   drive(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 1'b1);
        default:  drive(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 1'b0);
      endcase
      @(negedge clk); model_comb();
      p = prog_req;
      if (mem_we_o === 1'b1 && m_q.size() != 0) we_bad++;
      nvec++;
      if (dut_vec() !== exp_vec()) begin
        $display("FAIL turn cyc=%0d p=%b got=%h exp=%h", cyc, p, dut_vec(), exp_vec()); nmis++;
      end
      if (i >= 6 && i <= 10) begin
        nvec++;
        if (mem_we_o !== 1'b0) begin
          $display("FAIL turn_no_write cyc=%0d got we=%b exp 0", cyc, mem_we_o); nmis++;
        end
      end
      tick();
    end
    nvec++;
    if (we_bad != 0) begin
      $display("FAIL write_during_reads got=%0d exp=0", we_bad); nmis++;
    end
  endtask

  task automatic test_proto_err();
    for (int i = 0; i < 12; i++) begin
      if (i < 3 || (i > 3 && i < 9)) drive(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, i < 3 ? last_rd : 1'b0);
      else if (i == 3) drive(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 1'b1);
      else drive(1'b0, 12'h0, 32'h0, 1'b1, 12'h0F0, 1'b0);
      @(negedge clk); model_comb();
      nvec++;
      if (dut_vec() !== exp_vec()) begin
        $display("FAIL proto_err cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); nmis++;
      end
      if (i > 3) begin
        nvec++;
        if (proto_err_o !== 1'b1) begin
          $display("FAIL proto_err_sticky cyc=%0d got=%b exp=1", cyc, proto_err_o); nmis++;
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 2) != 0, 12'($urandom), $urandom, $urandom_range(0, 2) != 0, 12'($urandom),
            (m_q.size() > 0) && ($urandom_range(0, 3) != 0));
      @(negedge clk); model_comb();
      nvec++;
      if (dut_vec() !== exp_vec()) begin
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); nmis++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, (m_q.size() > 0));
      else drive(1'b1, 12'h111, 32'h5555_AAAA, 1'b1, 12'h0A0, 1'b0);
      if (i == 6) rst_n = 1'b0;
      if (i == 7) rst_n = 1'b1;
      @(negedge clk); model_comb();
      nvec++;
      if (dut_vec() !== exp_vec()) begin
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); nmis++;
      end
      if (i == 6) begin
        nvec++;
        if ({prog_gnt_o, fetch_gnt_o, mem_req_o, mem_we_o, mem_addr_o, proto_err_o} !== 17'h0) begin
          $display("FAIL reset_mid_outputs got gnt=%b%b req=%b we=%b addr=%h err=%b exp all 0",
                   prog_gnt_o, fetch_gnt_o, mem_req_o, mem_we_o, mem_addr_o, proto_err_o); nmis++;
        end
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 12'h0, 32'h0, 1'b1, 12'h0B0 + 12'(i), 1'b0);
      @(negedge clk); model_comb();
      nvec++;
      if (dut_vec() !== exp_vec()) begin
        $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); nmis++;
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 1'b0);
    model_clear();
    test_reset();
    test_fetch_stream();
    test_outst_limit();
    test_write_switch();
    test_both_high();
    test_turn();
    test_proto_err();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
